// File: rtl/timer_cmd_sequencer.sv
// Timer command sequencer: expands high-level timer commands into byte/word
// reads, read-modify-write and load-strobe sequences on the timer request port.
`ifndef ADDR_W
`define ADDR_W 32
`endif
`ifndef WORD_W
`define WORD_W 32
`endif
`ifndef MEM_COUNT_W
`define MEM_COUNT_W 2
`endif
`ifndef MEM_COUNT_NONE
`define MEM_COUNT_NONE 2'd0
`endif
`ifndef MEM_COUNT_BYTE
`define MEM_COUNT_BYTE 2'd1
`endif
`ifndef MEM_COUNT_WORD
`define MEM_COUNT_WORD 2'd2
`endif
`ifndef MEM_CODE_W
`define MEM_CODE_W 2
`endif

module timer_cmd_sequencer #(
   parameter int                ADDR_W   = `ADDR_W,
   parameter int                WORD_W   = `WORD_W,
   parameter logic [ADDR_W-1:0] TMR_BASE = '0
) (
   input  logic                    clk,
   input  logic                    reset,
   input  logic                    i_cmd_valid,
   output logic                    o_cmd_ready,
   input  logic [2:0]              i_cmd_op,
   input  logic [WORD_W-1:0]       i_cmd_arg,
   output logic                    o_rsp_valid,
   output logic [WORD_W-1:0]       o_rsp_data,
   output logic                    o_rsp_err,
   output logic [ADDR_W-1:0]       o_req_addr,
   output logic [WORD_W-1:0]       o_req_wr_data,
   output logic                    o_req_wr_en,
   output logic [`MEM_COUNT_W-1:0] o_req_count,
   input  logic [WORD_W-1:0]       i_res_rd_data,
   input  logic [`MEM_CODE_W-1:0]  i_res_code
);

   localparam logic [2:0] S_IDLE       = 3'd0;
   localparam logic [2:0] S_WR_WORD    = 3'd1;
   localparam logic [2:0] S_RD_REQ     = 3'd2;
   localparam logic [2:0] S_CAP        = 3'd3;
   localparam logic [2:0] S_WR_CTRL    = 3'd4;
   localparam logic [2:0] S_WR_RESTORE = 3'd5;
   localparam logic [2:0] S_RSP        = 3'd6;

   localparam logic [2:0] OP_START      = 3'd0;
   localparam logic [2:0] OP_STOP       = 3'd1;
   localparam logic [2:0] OP_SET_DIR    = 3'd2;
   localparam logic [2:0] OP_SET_TRIG   = 3'd3;
   localparam logic [2:0] OP_SET_THRESH = 3'd4;
   localparam logic [2:0] OP_LOAD       = 3'd5;
   localparam logic [2:0] OP_READ_COUNT = 3'd6;
   localparam logic [2:0] OP_RSV        = 3'd7;

   localparam logic [ADDR_W-1:0] ADDR_CTRL   = TMR_BASE;
   localparam logic [ADDR_W-1:0] ADDR_THRESH = TMR_BASE + ADDR_W'(4);
   localparam logic [ADDR_W-1:0] ADDR_LOAD   = TMR_BASE + ADDR_W'(8);
   localparam logic [ADDR_W-1:0] ADDR_COUNT  = TMR_BASE + ADDR_W'(8'h16);

   logic [2:0]              state_q, state_d;
   logic [2:0]              op_q, op_d;
   logic [WORD_W-1:0]       arg_q, arg_d;
   logic [WORD_W-1:0]       cap_q, cap_d;
   logic [ADDR_W-1:0]       req_addr_q, req_addr_d;
   logic [WORD_W-1:0]       req_wr_data_q, req_wr_data_d;
   logic                    req_wr_en_q, req_wr_en_d;
   logic [`MEM_COUNT_W-1:0] req_count_q, req_count_d;
   logic                    rsp_valid_q, rsp_valid_d;
   logic [WORD_W-1:0]       rsp_data_q, rsp_data_d;
   logic                    rsp_err_q, rsp_err_d;

   logic                    accept;
   logic [2:0]              op;
   logic [WORD_W-1:0]       arg;
   logic [7:0]              old_ctrl, new_ctrl;
   logic                    unused_res_code;

   assign unused_res_code = ^i_res_code;
   assign o_cmd_ready     = (state_q == S_IDLE) && !reset;
   assign accept          = i_cmd_valid && o_cmd_ready;

   // Outputs for the next cycle are built at the accept edge, so use the live op/arg then.
   always_comb begin
      op       = accept ? i_cmd_op  : op_q;
      arg      = accept ? i_cmd_arg : arg_q;
      old_ctrl = i_res_rd_data[7:0];
      case (op)
         OP_START:    new_ctrl = old_ctrl | 8'h08;
         OP_STOP:     new_ctrl = old_ctrl & 8'hF7;
         OP_SET_DIR:  new_ctrl = {old_ctrl[7:3], arg[0], old_ctrl[1:0]};
         OP_SET_TRIG: new_ctrl = {old_ctrl[7:1], arg[0]};
         default:     new_ctrl = old_ctrl ^ 8'h02;
      endcase
   end

   always_comb begin
      state_d = state_q;
      op_d    = op_q;
      arg_d   = arg_q;
      cap_d   = cap_q;
      case (state_q)
         S_IDLE: begin
            if (accept) begin
               op_d  = i_cmd_op;
               arg_d = i_cmd_arg;
               case (i_cmd_op)
                  OP_SET_THRESH, OP_LOAD: state_d = S_WR_WORD;
                  OP_RSV:                 state_d = S_RSP;
                  default:                state_d = S_RD_REQ;
               endcase
            end
         end
         S_WR_WORD:    state_d = (op_q == OP_LOAD) ? S_RD_REQ : S_RSP;
         S_RD_REQ:     state_d = S_CAP;
         S_CAP: begin
            state_d = (op_q == OP_READ_COUNT) ? S_RSP : S_WR_CTRL;
            // LOAD keeps the original byte for the restore write and the response.
            if (op_q == OP_READ_COUNT) cap_d = i_res_rd_data;
            else if (op_q == OP_LOAD)  cap_d = {{(WORD_W-8){1'b0}}, old_ctrl};
            else                       cap_d = {{(WORD_W-8){1'b0}}, new_ctrl};
         end
         S_WR_CTRL:    state_d = (op_q == OP_LOAD) ? S_WR_RESTORE : S_RSP;
         S_WR_RESTORE: state_d = S_RSP;
         default:      state_d = S_IDLE;
      endcase
   end

   always_comb begin
      req_addr_d    = '0;
      req_wr_data_d = '0;
      req_wr_en_d   = 1'b0;
      req_count_d   = `MEM_COUNT_NONE;
      rsp_valid_d   = 1'b0;
      rsp_data_d    = '0;
      rsp_err_d     = 1'b0;
      case (state_d)
         S_WR_WORD: begin
            req_addr_d    = (op == OP_LOAD) ? ADDR_LOAD : ADDR_THRESH;
            req_wr_data_d = arg;
            req_wr_en_d   = 1'b1;
            req_count_d   = `MEM_COUNT_WORD;
         end
         S_RD_REQ: begin
            if (op == OP_READ_COUNT) begin
               req_addr_d  = ADDR_COUNT;
               req_count_d = `MEM_COUNT_WORD;
            end else begin
               req_addr_d  = ADDR_CTRL;
               req_count_d = `MEM_COUNT_BYTE;
            end
         end
         S_WR_CTRL: begin
            req_addr_d    = ADDR_CTRL;
            req_wr_data_d = {{(WORD_W-8){1'b0}}, new_ctrl};
            req_wr_en_d   = 1'b1;
            req_count_d   = `MEM_COUNT_BYTE;
         end
         S_WR_RESTORE: begin
            req_addr_d    = ADDR_CTRL;
            req_wr_data_d = cap_q;
            req_wr_en_d   = 1'b1;
            req_count_d   = `MEM_COUNT_BYTE;
         end
         S_RSP: begin
            rsp_valid_d = 1'b1;
            case (op)
               OP_RSV:        rsp_err_d  = 1'b1;
               OP_SET_THRESH: rsp_data_d = '0;
               default:       rsp_data_d = cap_d;
            endcase
         end
         default: ;
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q       <= S_IDLE;
         op_q          <= '0;
         arg_q         <= '0;
         cap_q         <= '0;
         req_addr_q    <= '0;
         req_wr_data_q <= '0;
         req_wr_en_q   <= 1'b0;
         req_count_q   <= `MEM_COUNT_NONE;
         rsp_valid_q   <= 1'b0;
         rsp_data_q    <= '0;
         rsp_err_q     <= 1'b0;
      end else begin
         state_q       <= state_d;
         op_q          <= op_d;
         arg_q         <= arg_d;
         cap_q         <= cap_d;
         req_addr_q    <= req_addr_d;
         req_wr_data_q <= req_wr_data_d;
         req_wr_en_q   <= req_wr_en_d;
         req_count_q   <= req_count_d;
         rsp_valid_q   <= rsp_valid_d;
         rsp_data_q    <= rsp_data_d;
         rsp_err_q     <= rsp_err_d;
      end
   end

   assign o_req_addr    = req_addr_q;
   assign o_req_wr_data = req_wr_data_q;
   assign o_req_wr_en   = req_wr_en_q;
   assign o_req_count   = req_count_q;
   assign o_rsp_valid   = rsp_valid_q;
   assign o_rsp_data    = rsp_data_q;
   assign o_rsp_err     = rsp_err_q;

endmodule

// File: tb/tb_timer_cmd_sequencer.sv
// Scoreboard bench for timer_cmd_sequencer: a behavioural timer answers bus
// requests; expected requests/responses with their cycle offsets are queued.
`ifndef ADDR_W
`define ADDR_W 32
`endif
`ifndef WORD_W
`define WORD_W 32
`endif
`ifndef MEM_COUNT_W
`define MEM_COUNT_W 2
`endif
`ifndef MEM_COUNT_NONE
`define MEM_COUNT_NONE 2'd0
`endif
`ifndef MEM_COUNT_BYTE
`define MEM_COUNT_BYTE 2'd1
`endif
`ifndef MEM_COUNT_WORD
`define MEM_COUNT_WORD 2'd2
`endif
`ifndef MEM_CODE_W
`define MEM_CODE_W 2
`endif

module tb_timer_cmd_sequencer;
   localparam int AW = `ADDR_W;
   localparam int WW = `WORD_W;
   localparam logic [1:0] C_NONE = `MEM_COUNT_NONE;
   localparam logic [1:0] C_BYTE = `MEM_COUNT_BYTE;
   localparam logic [1:0] C_WORD = `MEM_COUNT_WORD;
   localparam logic [WW-1:0] COUNT_VAL = 32'h0FFF_FFF0;

   logic clk = 1'b0;
   logic reset = 1'b1;
   logic i_cmd_valid = 1'b0;
   logic o_cmd_ready;
   logic [2:0] i_cmd_op = 3'd0;
   logic [WW-1:0] i_cmd_arg = '0;
   logic o_rsp_valid;
   logic [WW-1:0] o_rsp_data;
   logic o_rsp_err;
   logic [AW-1:0] o_req_addr;
   logic [WW-1:0] o_req_wr_data;
   logic o_req_wr_en;
   logic [`MEM_COUNT_W-1:0] o_req_count;
   logic [WW-1:0] i_res_rd_data = '0;
   logic [`MEM_CODE_W-1:0] i_res_code = '0;

   timer_cmd_sequencer dut (
      .clk(clk), .reset(reset),
      .i_cmd_valid(i_cmd_valid), .o_cmd_ready(o_cmd_ready),
      .i_cmd_op(i_cmd_op), .i_cmd_arg(i_cmd_arg),
      .o_rsp_valid(o_rsp_valid), .o_rsp_data(o_rsp_data), .o_rsp_err(o_rsp_err),
      .o_req_addr(o_req_addr), .o_req_wr_data(o_req_wr_data),
      .o_req_wr_en(o_req_wr_en), .o_req_count(o_req_count),
      .i_res_rd_data(i_res_rd_data), .i_res_code(i_res_code)
   );

   always #5 clk = ~clk;

   typedef struct {
      int k; logic [AW-1:0] addr; logic [WW-1:0] data; logic we; logic [1:0] cnt;
   } req_t;
   typedef struct {
      int k; logic [WW-1:0] data; logic err;
   } rsp_t;

   req_t exp_req[$];
   rsp_t exp_rsp[$];
   int total = 0;
   int bad = 0;
   int cyc = 0;
   int acc = 0;
   int acc_hist[$];
   int rsp_hist[$];
   bit mon_en = 1'b0;

   // behavioural timer: registered read data, byte/word writes
   logic [7:0] m_ctrl = 8'h00;
   logic [WW-1:0] m_thresh = '0;
   logic [WW-1:0] m_load = '0;
   logic [7:0] preset_val = 8'h00;
   logic preset_stb = 1'b0;

   initial forever begin
      @(posedge clk);
      if (preset_stb) m_ctrl <= preset_val;
      else if (o_req_wr_en && o_req_count != C_NONE && o_req_addr == 32'h0)
         m_ctrl <= o_req_wr_data[7:0];
      if (o_req_wr_en && o_req_count != C_NONE) begin
         if (o_req_addr == 32'h4) m_thresh <= o_req_wr_data;
         if (o_req_addr == 32'h8) m_load <= o_req_wr_data;
      end
      if (!o_req_wr_en && o_req_count != C_NONE) begin
         case (o_req_addr)
            32'h00:  i_res_rd_data <= {24'hA5A5A5, m_ctrl};
            32'h04:  i_res_rd_data <= m_thresh;
            32'h08:  i_res_rd_data <= m_load;
            32'h16:  i_res_rd_data <= COUNT_VAL;
            default: i_res_rd_data <= 32'hDEADBEEF;
         endcase
      end
   end

   // accept tracker: cycle k after an accept is seen with cyc - acc == k
   initial forever begin
      @(posedge clk);
      if (i_cmd_valid && o_cmd_ready) begin
         acc = cyc;
         acc_hist.push_back(cyc);
      end
      cyc = cyc + 1;
   end

   // monitor
   initial forever begin : mon
      int k;
      req_t e;
      rsp_t r;
      @(negedge clk);
      if (mon_en) begin
         k = cyc - acc;
         if (o_req_count != C_NONE) begin
            total++;
            if (exp_req.size() == 0) begin
               bad++;
               $display("FAIL req_unexpected: k=%0d addr=%0h cnt=%0d we=%0b", k, o_req_addr, o_req_count, o_req_wr_en);
            end else begin
               e = exp_req.pop_front();
               if (k != e.k || o_req_addr !== e.addr || o_req_count !== e.cnt ||
                   o_req_wr_en !== e.we || (e.we && o_req_wr_data !== e.data)) begin
                  bad++;
                  $display("FAIL req: got k=%0d addr=%0h cnt=%0d we=%0b data=%0h, want k=%0d addr=%0h cnt=%0d we=%0b data=%0h",
                           k, o_req_addr, o_req_count, o_req_wr_en, o_req_wr_data, e.k, e.addr, e.cnt, e.we, e.data);
               end
            end
         end else begin
            total++;
            if (o_req_wr_en !== 1'b0) begin
               bad++;
               $display("FAIL idle_wr_en: got %0b want 0", o_req_wr_en);
            end
         end
         if (o_rsp_valid === 1'b1) begin
            rsp_hist.push_back(cyc);
            total++;
            if (exp_rsp.size() == 0) begin
               bad++;
               $display("FAIL rsp_unexpected: k=%0d data=%0h err=%0b", k, o_rsp_data, o_rsp_err);
            end else begin
               r = exp_rsp.pop_front();
               if (k != r.k || o_rsp_data !== r.data || o_rsp_err !== r.err) begin
                  bad++;
                  $display("FAIL rsp: got k=%0d data=%0h err=%0b, want k=%0d data=%0h err=%0b",
                           k, o_rsp_data, o_rsp_err, r.k, r.data, r.err);
               end
            end
         end
      end
   end

   task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %0h want %0h", nm, act, exp);
      end
   endtask

   task automatic push_req(input int k, input logic [31:0] a, input logic [31:0] d,
                           input logic we, input logic [1:0] c);
      req_t e;
      e.k = k; e.addr = a; e.data = d; e.we = we; e.cnt = c;
      exp_req.push_back(e);
   endtask

   task automatic push_rsp(input int k, input logic [31:0] d, input logic err);
      rsp_t r;
      r.k = k; r.data = d; r.err = err;
      exp_rsp.push_back(r);
   endtask

   task automatic preset(input logic [7:0] v);
      @(negedge clk);
      preset_val = v;
      preset_stb = 1'b1;
      @(negedge clk);
      preset_stb = 1'b0;
   endtask

   // returns at the negedge of cycle 1
   task automatic send(input logic [2:0] op, input logic [31:0] arg);
      int n;
      n = 0;
      @(negedge clk);
      i_cmd_valid = 1'b1;
      i_cmd_op = op;
      i_cmd_arg = arg;
      while (!o_cmd_ready && n < 50) begin
         @(negedge clk);
         n++;
      end
      if (n >= 50) begin
         total++; bad++;
         $display("FAIL send_timeout: ready stayed %0b want 1", o_cmd_ready);
      end
      @(negedge clk);
      i_cmd_valid = 1'b0;
   endtask

   task automatic drain();
      int n;
      n = 0;
      while ((exp_req.size() != 0 || exp_rsp.size() != 0) && n < 40) begin
         @(negedge clk);
         n++;
      end
      total++;
      if (n >= 40) begin
         bad++;
         $display("FAIL drain_timeout: pending req=%0d rsp=%0d want 0", exp_req.size(), exp_rsp.size());
         exp_req.delete();
         exp_rsp.delete();
      end
      @(negedge clk);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached, want completion");
      $display("test done: total=%0d bad=%0d", total, bad + 1);
      $fatal(1);
   end

   initial begin
      // reset state
      repeat (3) @(negedge clk);
      mon_en = 1'b1;
      chk("rst_ready", o_cmd_ready, 0);
      chk("rst_addr", o_req_addr, 0);
      chk("rst_wdata", o_req_wr_data, 0);
      chk("rst_wr_en", o_req_wr_en, 0);
      chk("rst_count", o_req_count, C_NONE);
      chk("rst_rsp_valid", o_rsp_valid, 0);
      chk("rst_rsp_data", o_rsp_data, 0);
      chk("rst_rsp_err", o_rsp_err, 0);
      reset = 1'b0;
      @(negedge clk);
      chk("ready_after_rst", o_cmd_ready, 1);

      // reset mid-LOAD, asserted in cycle 4
      preset(8'h00);
      push_req(1, 32'h8, 32'h1234_5678, 1'b1, C_WORD);
      push_req(2, 32'h0, 32'h0, 1'b0, C_BYTE);
      push_req(4, 32'h0, 32'h02, 1'b1, C_BYTE);
      send(3'd5, 32'h1234_5678);
      repeat (3) @(negedge clk);
      reset = 1'b1;
      @(negedge clk);
      chk("abort_count", o_req_count, C_NONE);
      chk("abort_wr_en", o_req_wr_en, 0);
      chk("abort_rsp", o_rsp_valid, 0);
      chk("abort_ready_in_rst", o_cmd_ready, 0);
      repeat (2) @(negedge clk);
      reset = 1'b0;
      @(negedge clk);
      chk("abort_ready_after", o_cmd_ready, 1);
      chk("abort_reqs_seen", exp_req.size(), 0);
      exp_req.delete();

      // LOAD on ctrl 0x00
      preset(8'h00);
      push_req(1, 32'h8, 32'h1000_0000, 1'b1, C_WORD);
      push_req(2, 32'h0, 32'h0, 1'b0, C_BYTE);
      push_req(4, 32'h0, 32'h02, 1'b1, C_BYTE);
      push_req(5, 32'h0, 32'h00, 1'b1, C_BYTE);
      push_rsp(6, 32'h00, 1'b0);
      send(3'd5, 32'h1000_0000);
      drain();

      // START then STOP on 0x05
      preset(8'h05);
      push_req(1, 32'h0, 32'h0, 1'b0, C_BYTE);
      push_req(3, 32'h0, 32'h0D, 1'b1, C_BYTE);
      push_rsp(4, 32'h0D, 1'b0);
      send(3'd0, 32'h0);
      drain();
      push_req(1, 32'h0, 32'h0, 1'b0, C_BYTE);
      push_req(3, 32'h0, 32'h05, 1'b1, C_BYTE);
      push_rsp(4, 32'h05, 1'b0);
      send(3'd1, 32'h0);
      drain();

      // SET_DIR / SET_TRIG_EN preserve other bits
      preset(8'h08);
      push_req(1, 32'h0, 32'h0, 1'b0, C_BYTE);
      push_req(3, 32'h0, 32'h0C, 1'b1, C_BYTE);
      push_rsp(4, 32'h0C, 1'b0);
      send(3'd2, 32'h1);
      drain();
      push_req(1, 32'h0, 32'h0, 1'b0, C_BYTE);
      push_req(3, 32'h0, 32'h0D, 1'b1, C_BYTE);
      push_rsp(4, 32'h0D, 1'b0);
      send(3'd3, 32'hFFFF_FFF1);
      drain();
      push_req(1, 32'h0, 32'h0, 1'b0, C_BYTE);
      push_req(3, 32'h0, 32'h09, 1'b1, C_BYTE);
      push_rsp(4, 32'h09, 1'b0);
      send(3'd2, 32'h2);
      drain();
      push_req(1, 32'h0, 32'h0, 1'b0, C_BYTE);
      push_req(3, 32'h0, 32'h08, 1'b1, C_BYTE);
      push_rsp(4, 32'h08, 1'b0);
      send(3'd3, 32'h0);
      drain();
      preset(8'h0A);
      push_req(1, 32'h0, 32'h0, 1'b0, C_BYTE);
      push_req(3, 32'h0, 32'h02, 1'b1, C_BYTE);
      push_rsp(4, 32'h02, 1'b0);
      send(3'd1, 32'h0);
      drain();

      // SET_THRESH and READ_COUNT
      push_req(1, 32'h4, 32'h1000_0000, 1'b1, C_WORD);
      push_rsp(2, 32'h0, 1'b0);
      send(3'd4, 32'h1000_0000);
      drain();
      push_req(1, 32'h16, 32'h0, 1'b0, C_WORD);
      push_rsp(3, COUNT_VAL, 1'b0);
      send(3'd6, 32'h0);
      drain();

      // reserved opcode
      push_rsp(1, 32'h0, 1'b1);
      send(3'd7, 32'hFFFF_FFFF);
      drain();

      // valid held across completion
      acc_hist.delete();
      rsp_hist.delete();
      push_req(1, 32'h4, 32'hCAFE_0001, 1'b1, C_WORD);
      push_rsp(2, 32'h0, 1'b0);
      push_req(1, 32'h4, 32'hCAFE_0001, 1'b1, C_WORD);
      push_rsp(2, 32'h0, 1'b0);
      @(negedge clk);
      i_cmd_valid = 1'b1;
      i_cmd_op = 3'd4;
      i_cmd_arg = 32'hCAFE_0001;
      for (int n = 0; n < 20 && acc_hist.size() < 2; n++) @(negedge clk);
      i_cmd_valid = 1'b0;
      drain();
      chk("held_accepts", acc_hist.size(), 2);
      if (acc_hist.size() >= 2 && rsp_hist.size() >= 1)
         chk("held_accept_gap", acc_hist[1], rsp_hist[0] + 1);
      else begin
         total++; bad++;
         $display("FAIL held_accept_gap: accepts=%0d rsps=%0d want 2 and 1", acc_hist.size(), rsp_hist.size());
      end
      repeat (3) @(negedge clk);
      chk("final_req_q", exp_req.size(), 0);
      chk("final_rsp_q", exp_rsp.size(), 0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
